// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - Datapath <-> hazard controller signal bundle
// Purpose: groups the pipeline register addresses and controls seen by the hazard
//          controller together with the stall/flush/forward/timeout outputs it returns.
// Modports:
//   master - datapath side: drives register addresses/controls, receives stall/flush/forward
//   slave  - hazard controller side: receives addresses/controls, drives stall/flush/forward
interface hazard_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]        ResultSrcE;
    logic              RegWriteM, RegWriteW, PCSrcE, MemAccM, MemReadyM;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              MemTimeout;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemAccM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemTimeout
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemAccM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemTimeout
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller with memory wait-state FSM
// Purpose: operand forwarding selects for Execute, load-use stall, branch flush, and a
//          RUN/WAIT/ERR FSM that freezes the pipeline while data memory is not ready.
// Ports:
//   clk        - clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   hz         - hazard_ctrl_if.slave: register addresses/controls in, stall/flush/forward out
//   StallCnt, FlushCnt, WaitCnt - performance counters (only with PERF_COUNTERS_EN)
// Configuration macro: PERF_COUNTERS_EN adds the saturating performance counters.
module hazard_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 16
`ifdef PERF_COUNTERS_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
`ifdef PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] WaitCnt
`endif
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            mem_wait;
    logic            lw_stall;
    logic            freeze;
    logic [ADDR_W-1:0] zero_reg;

    assign zero_reg = {ADDR_W{1'b0}};
    assign mem_wait = hz.MemAccM & ~hz.MemReadyM;
    assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != zero_reg) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    // The first wait cycle freezes from the live inputs so there is no one-cycle lag.
    assign freeze   = (state_q == ST_ERR) || mem_wait;

    // Memory wait-state FSM next state. Leaving WAIT on any non-waiting cycle also
    // covers the illegal case of MemAccM dropping mid-wait.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = CW'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_wait) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CW'(MAX_WAIT)) begin
                    state_d    = ST_ERR;
                end else if (wait_cnt_q != {CW{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Stall/flush/forward. Priority: reset, then freeze, then branch over load-use.
    always_comb begin
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.StallM    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushW    = 1'b0;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (!rst_n) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
            hz.FlushW = 1'b1;
        end else begin
            if (hz.RegWriteM && hz.RdM != zero_reg && hz.RdM == hz.Rs1E)
                hz.ForwardAE = 2'b10;
            else if (hz.RegWriteW && hz.RdW != zero_reg && hz.RdW == hz.Rs1E)
                hz.ForwardAE = 2'b01;
            if (hz.RegWriteM && hz.RdM != zero_reg && hz.RdM == hz.Rs2E)
                hz.ForwardBE = 2'b10;
            else if (hz.RegWriteW && hz.RdW != zero_reg && hz.RdW == hz.Rs2E)
                hz.ForwardBE = 2'b01;

            if (freeze) begin
                // E/M are held, so a pending branch or load-use re-asserts after release.
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end else begin
                hz.FlushD = hz.PCSrcE;
                hz.FlushE = hz.PCSrcE | lw_stall;
                hz.StallF = lw_stall & ~hz.PCSrcE;
                hz.StallD = lw_stall & ~hz.PCSrcE;
            end
        end
    end

    assign hz.MemTimeout = (state_q == ST_ERR);

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_perf_q, wait_perf_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_perf_d = wait_perf_q;
        if (!freeze && lw_stall && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (!freeze && hz.PCSrcE && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (freeze && !(&wait_perf_q))
            wait_perf_d = wait_perf_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_perf_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_perf_q <= wait_perf_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
    assign WaitCnt  = wait_perf_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - Directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.ADDR_W(5)) hz ();

`ifdef PERF_COUNTERS_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    hazard_ctrl #(.ADDR_W(5), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
`ifdef PERF_COUNTERS_EN
        ,
        .StallCnt (stall_cnt),
        .FlushCnt (flush_cnt),
        .WaitCnt  (wait_cnt)
`endif
    );

    typedef struct {
        string       name;
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0]  rsrc;
        logic        rwm, rww, pc, macc, mrdy;
        logic [10:0] exp;
    } vec_t;

    // Expected field order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
    localparam logic [10:0] O_RESET  = 11'b0000_111_00_00;
    localparam logic [10:0] O_FREEZE = 11'b1111_001_00_00;
    localparam logic [10:0] O_BRANCH = 11'b0000_110_00_00;
    localparam logic [10:0] O_LU     = 11'b1100_010_00_00;

    function automatic vec_t mk(string n, logic [4:0] rs1d, logic [4:0] rs2d,
                                logic [4:0] rs1e, logic [4:0] rs2e, logic [4:0] rde,
                                logic [4:0] rdm, logic [4:0] rdw, logic [1:0] rsrc,
                                logic rwm, logic rww, logic pc, logic macc, logic mrdy,
                                logic [10:0] e);
        vec_t v;
        v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rsrc = rsrc; v.rwm = rwm;
        v.rww = rww; v.pc = pc; v.macc = macc; v.mrdy = mrdy; v.exp = e;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
                hz.FlushW, hz.ForwardAE, hz.ForwardBE};
    endfunction

    task automatic drive(vec_t v);
        hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
        hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw; hz.ResultSrcE = v.rsrc;
        hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww; hz.PCSrcE = v.pc;
        hz.MemAccM = v.macc; hz.MemReadyM = v.mrdy;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    vec_t idle;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle = mk("idle",0,0,0,0,0,0,0,2'd0,0,0,0,0,0, 11'd0);
        vecs.push_back(idle);
        vecs.push_back(mk("fwdA_M",    0,0,5,0,0,5,5,2'd0,1,1,0,0,0, 11'b0000_000_10_00));
        vecs.push_back(mk("fwdA_W",    0,0,5,0,0,0,5,2'd0,1,1,0,0,0, 11'b0000_000_01_00));
        vecs.push_back(mk("fwdB_M",    0,0,3,7,0,7,7,2'd0,1,1,0,0,0, 11'b0000_000_00_10));
        vecs.push_back(mk("fwd_noWrM", 0,0,9,9,0,9,9,2'd0,0,1,0,0,0, 11'b0000_000_01_01));
        vecs.push_back(mk("fwd_x0",    0,0,0,0,0,0,0,2'd0,1,1,0,0,0, 11'b0000_000_00_00));
        vecs.push_back(mk("fwd_bothM", 0,0,6,6,0,6,2,2'd0,1,1,0,0,0, 11'b0000_000_10_10));
        vecs.push_back(mk("lu_rs2",    1,3,0,0,3,0,0,2'd1,0,0,0,0,0, O_LU));
        vecs.push_back(mk("lu_rd0",    0,0,0,0,0,0,0,2'd1,0,0,0,0,0, 11'd0));
        vecs.push_back(mk("lu_rs1",    4,9,0,0,4,0,0,2'd1,0,0,0,0,0, O_LU));
        vecs.push_back(mk("not_load",  4,0,0,0,4,0,0,2'd0,0,0,0,0,0, 11'd0));
        vecs.push_back(mk("branch",    0,0,0,0,0,0,0,2'd0,0,0,1,0,0, O_BRANCH));
        vecs.push_back(mk("br_lu",     1,3,0,0,3,0,0,2'd1,0,0,1,0,0, O_BRANCH));
        vecs.push_back(mk("mem_rdy",   3,0,0,0,3,0,0,2'd2,0,0,0,1,1, 11'd0));

        // Reset state
        drive(mk("rst_fwd",0,0,5,0,0,5,0,2'd0,1,0,1,0,0, 11'd0));
        #12;
        check("reset_outs", 32'(outs()), 32'(O_RESET));
        check("reset_timeout", 32'(hz.MemTimeout), 32'd0);
        drive(idle);
        #1 rst_n = 1'b1;
        tick();

        // Combinational vectors in RUN
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            tick();
        end
        drive(idle);
        tick();

        // Memory wait: 3 frozen cycles with a branch pending, release on ready
        drive(mk("wait",0,0,0,0,0,0,0,2'd0,0,0,1,1,0, 11'd0));
        #1;
        check("wait_c0", 32'(outs()), 32'(O_FREEZE));
        for (int c = 1; c < 3; c++) begin
            tick();
            check("wait_cN", 32'(outs()), 32'(O_FREEZE));
        end
        tick();
        hz.MemReadyM = 1'b1;
        #1;
        check("wait_release", 32'(outs()), 32'(O_BRANCH));
        tick();
        check("wait_state_run", 32'(dut.state_q), 32'd0);
        check("wait_no_timeout", 32'(hz.MemTimeout), 32'd0);
        drive(idle);
        tick();

        // Timeout with MAX_WAIT=4
        hz.MemAccM = 1'b1;
        hz.MemReadyM = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("to_edge4", 32'(hz.MemTimeout), 32'd0);
        tick();
        check("to_edge5", 32'(hz.MemTimeout), 32'd1);
        hz.MemReadyM = 1'b1;
        hz.MemAccM = 1'b0;
        tick();
        tick();
        check("to_sticky", 32'(hz.MemTimeout), 32'd1);
        check("to_frozen", 32'(outs()), 32'(O_FREEZE));
        hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.Rs1E = 5'd5;
        #2 rst_n = 1'b0;
        #1;
        check("to_rst_timeout", 32'(hz.MemTimeout), 32'd0);
        check("to_rst_outs", 32'(outs()), 32'(O_RESET));
        drive(idle);
        #1 rst_n = 1'b1;
        tick();

        // Async reset mid-WAIT
        hz.MemAccM = 1'b1;
        hz.MemReadyM = 1'b0;
        tick();
        tick();
        check("mw_in_wait", 32'(dut.state_q), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mw_rst_state", 32'(dut.state_q), 32'd0);
        check("mw_rst_outs", 32'(outs()), 32'(O_RESET));
        drive(idle);
        #1 rst_n = 1'b1;
        tick();
        check("mw_after_state", 32'(dut.state_q), 32'd0);
        check("mw_after_outs", 32'(outs()), 32'd0);

        // MemAccM dropping in WAIT returns to RUN
        hz.MemAccM = 1'b1;
        tick();
        hz.MemAccM = 1'b0;
        #1;
        check("drop_unfrozen", 32'(outs()), 32'd0);
        tick();
        check("drop_state_run", 32'(dut.state_q), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
